// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit, req/ack data bus, load align/extend, stall (optional MISALIGN_TRAP_EN adds misalign_exc)
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   alu_res_in,
  input  logic [XLEN-1:0]   store_data_in,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [3:0]        dbus_be,
  input  logic [XLEN-1:0]   dbus_rdata,
  input  logic              dbus_ack,
  output logic [XLEN-1:0]   mem_data_out,
  output logic [XLEN-1:0]   alu_res_out,
  output logic [4:0]        rd_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_exc,
`endif
  output logic              stall
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, nxt;
  logic mem_op, is_b, is_h, mis, ld_b, ld_h, ld_sgn;
  logic [1:0] off, h_off, off_q, ld_hoff;
  logic [2:0] f3_q;
  logic [3:0] be_n;
  logic [XLEN-1:0] wdata_n, ext;
  logic [7:0] lb;
  logic [15:0] lh;
  assign mem_op = mem_read_in | mem_write_in;
  assign off = alu_res_in[1:0];
  assign is_b = mem_write_in ? funct3_in == 3'b000 : funct3_in[1:0] == 2'b00;
  assign is_h = mem_write_in ? funct3_in == 3'b001 : funct3_in[1:0] == 2'b01;
`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign mis = (is_h & off == 2'b11) | (!is_b & !is_h & off != 2'b00);
  assign h_off = off;
  assign ld_hoff = off_q;
`else
  assign mis = 1'b0;
  assign h_off = {off[1], 1'b0};
  assign ld_hoff = {off_q[1], 1'b0};
`endif
  assign be_n = is_b ? 4'b0001 << off : is_h ? 4'b0011 << h_off : 4'b1111;
  assign wdata_n = is_b ? {4{store_data_in[7:0]}} :
                   is_h ? (h_off[0] ? {store_data_in[7:0], store_data_in[15:0], store_data_in[7:0]}
                                    : {2{store_data_in[15:0]}}) : store_data_in;
  assign ld_b = f3_q[1:0] == 2'b00;
  assign ld_h = f3_q[1:0] == 2'b01;
  assign ld_sgn = !f3_q[2];
  assign lb = 8'(dbus_rdata >> {off_q, 3'b000});
  assign lh = 16'(dbus_rdata >> {ld_hoff, 3'b000});
  assign ext = ld_b ? {{24{ld_sgn & lb[7]}}, lb} : ld_h ? {{16{ld_sgn & lh[15]}}, lh} : dbus_rdata;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (mem_op ? (mis ? DONE : BUS) : IDLE) :
          state == BUS  ? (dbus_ack ? DONE : BUS) : IDLE;
  always_comb begin
    stall = !rst & ((state == IDLE & mem_op) | state == BUS);
    alu_res_out = alu_res_in;
    rd_out = rd_in;
    mem_to_reg_out = mem_to_reg_in;
`ifdef MISALIGN_TRAP_EN
    misalign_exc = state == DONE & mis_q;
    reg_write_out = reg_write_in & !misalign_exc;
`else
    reg_write_out = reg_write_in;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req <= 1'b0;
      dbus_we <= 1'b0;
      dbus_addr <= '0;
      dbus_wdata <= '0;
      dbus_be <= '0;
      mem_data_out <= '0;
      f3_q <= '0;
      off_q <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && mem_op && !mis) begin
        dbus_req <= 1'b1;
        dbus_we <= mem_write_in;
        dbus_addr <= {alu_res_in[ADDR_W-1:2], 2'b00};
        dbus_wdata <= wdata_n;
        dbus_be <= be_n;
        f3_q <= funct3_in;
        off_q <= off;
      end
      if (state == BUS && dbus_ack) begin
        dbus_req <= 1'b0;
        if (!dbus_we) mem_data_out <= ext;
      end
`ifdef MISALIGN_TRAP_EN
      if (state == IDLE) mis_q <= mem_op & mis;
      if (state == IDLE && mem_op && mis) mem_data_out <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table-driven bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 0, rst = 1, mem_read_in = 0, mem_write_in = 0, reg_write_in = 0, mem_to_reg_in = 0, dbus_ack = 0;
  logic [2:0] funct3_in = 0;
  logic [31:0] alu_res_in = 0, store_data_in = 0, dbus_rdata = 0;
  logic [4:0] rd_in = 0;
  logic dbus_req, dbus_we, reg_write_out, mem_to_reg_out, stall;
  logic [31:0] dbus_addr, dbus_wdata, mem_data_out, alu_res_out;
  logic [3:0] dbus_be;
  logic [4:0] rd_out;
`ifdef MISALIGN_TRAP_EN
  logic misalign_exc;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, sdata, rdata;
    int dly;
    logic [3:0] be;
    logic [31:0] wdata, mdo;
    int stl;
  } vec_t;
  vec_t v[13];
  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .alu_res_in(alu_res_in), .store_data_in(store_data_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_be(dbus_be), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .mem_data_out(mem_data_out), .alu_res_out(alu_res_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
`ifdef MISALIGN_TRAP_EN
    .misalign_exc(misalign_exc),
`endif
    .stall(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int idx, input vec_t t);
    int n;
    @(negedge clk);
    mem_read_in = t.rd;
    mem_write_in = t.wr;
    funct3_in = t.f3;
    alu_res_in = t.addr;
    store_data_in = t.sdata;
    rd_in = 5'd7;
    reg_write_in = t.rd & !t.wr;
    mem_to_reg_in = t.rd & !t.wr;
    dbus_ack = 0;
    #1 chk($sformatf("v%0d stall_idle", idx), {31'b0, stall}, 1);
    n = 1;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d req", idx), {31'b0, dbus_req}, 1);
    chk($sformatf("v%0d we", idx), {31'b0, dbus_we}, {31'b0, t.wr});
    chk($sformatf("v%0d addr", idx), dbus_addr, t.addr & ~32'h3);
    chk($sformatf("v%0d be", idx), {28'b0, dbus_be}, {28'b0, t.be});
    chk($sformatf("v%0d wdata", idx), dbus_wdata, t.wdata);
    repeat (t.dly) begin
      @(negedge clk);
      if (stall) n++;
      chk($sformatf("v%0d req_hold", idx), {31'b0, dbus_req}, 1);
    end
    @(negedge clk);
    if (stall) n++;
    dbus_ack = 1;
    dbus_rdata = t.rdata;
    @(posedge clk);
    #1;
    dbus_ack = 0;
    dbus_rdata = 32'h5A5A5A5A;
    chk($sformatf("v%0d stall_done", idx), {31'b0, stall}, 0);
    chk($sformatf("v%0d stall_cycles", idx), n, t.stl);
    chk($sformatf("v%0d mem_data", idx), mem_data_out, t.mdo);
    chk($sformatf("v%0d req_drop", idx), {31'b0, dbus_req}, 0);
    chk($sformatf("v%0d alu_pass", idx), alu_res_out, t.addr);
    chk($sformatf("v%0d rd_pass", idx), {27'b0, rd_out}, 7);
    @(posedge clk);
  endtask
  initial begin
    v[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 4'hF, 32'h0,        32'hDEADBEEF, 4};
    v[1]  = '{1, 0, 3'b000, 32'h203, 32'h0,        32'h80FFFF00, 0, 4'h8, 32'h0,        32'hFFFFFF80, 2};
    v[2]  = '{1, 0, 3'b100, 32'h203, 32'h0,        32'h80FFFF00, 1, 4'h8, 32'h0,        32'h00000080, 3};
    v[3]  = '{1, 0, 3'b101, 32'h202, 32'h0,        32'h80FFFF00, 0, 4'hC, 32'h0,        32'h000080FF, 2};
    v[4]  = '{1, 0, 3'b001, 32'h200, 32'h0,        32'h80FFFF00, 0, 4'h3, 32'h0,        32'hFFFFFF00, 2};
    v[5]  = '{0, 1, 3'b000, 32'h301, 32'h000000AB, 32'h0,        1, 4'h2, 32'hABABABAB, 32'hFFFFFF00, 3};
    v[6]  = '{0, 1, 3'b001, 32'h302, 32'h00001234, 32'h0,        0, 4'hC, 32'h12341234, 32'hFFFFFF00, 2};
    v[7]  = '{0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0,        0, 4'hF, 32'hCAFEF00D, 32'hFFFFFF00, 2};
    v[8]  = '{1, 0, 3'b001, 32'h201, 32'h0,        32'h1234ABCD, 0, 4'h3, 32'h0,        32'hFFFFABCD, 2};
    v[9]  = '{1, 0, 3'b011, 32'h010, 32'h0,        32'h11223344, 0, 4'hF, 32'h0,        32'h11223344, 2};
    v[10] = '{1, 1, 3'b010, 32'h020, 32'h55AA55AA, 32'h99999999, 0, 4'hF, 32'h55AA55AA, 32'h11223344, 2};
    v[11] = '{1, 0, 3'b000, 32'h200, 32'h0,        32'h0000007F, 0, 4'h1, 32'h0,        32'h0000007F, 2};
    v[12] = '{1, 0, 3'b100, 32'h201, 32'h0,        32'h0000F000, 0, 4'h2, 32'h0,        32'h000000F0, 2};
    mem_read_in = 1;
    alu_res_in = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", {31'b0, stall}, 0);
    chk("rst req", {31'b0, dbus_req}, 0);
    chk("rst we", {31'b0, dbus_we}, 0);
    chk("rst addr", dbus_addr, 0);
    chk("rst wdata", dbus_wdata, 0);
    chk("rst be", {28'b0, dbus_be}, 0);
    chk("rst mem_data", mem_data_out, 0);
    chk("rst alu_pass", alu_res_out, 32'h44);
    @(negedge clk);
    rst = 0;
    mem_read_in = 0;
    alu_res_in = 32'h1234;
    rd_in = 5;
    reg_write_in = 1;
    mem_to_reg_in = 0;
    #1;
    chk("pass alu", alu_res_out, 32'h1234);
    chk("pass rd", {27'b0, rd_out}, 5);
    chk("pass rw", {31'b0, reg_write_out}, 1);
    chk("pass mtr", {31'b0, mem_to_reg_out}, 0);
    chk("pass stall", {31'b0, stall}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("pass no_req", {31'b0, dbus_req}, 0);
    end
    for (int i = 0; i < 13; i++) run_vec(i, v[i]);
    @(negedge clk);
    mem_read_in = 1;
    mem_write_in = 0;
    funct3_in = 3'b010;
    alu_res_in = 32'h100;
    @(posedge clk);
    #1 chk("rstbus req_up", {31'b0, dbus_req}, 1);
    @(negedge clk);
    rst = 1;
    dbus_ack = 1;
    dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    chk("rstbus req", {31'b0, dbus_req}, 0);
    chk("rstbus mem_data", mem_data_out, 0);
    chk("rstbus stall", {31'b0, stall}, 0);
    @(negedge clk);
    rst = 0;
    mem_read_in = 0;
    @(posedge clk);
    #1;
    chk("late_ack mem_data", mem_data_out, 0);
    chk("late_ack req", {31'b0, dbus_req}, 0);
    chk("late_ack stall", {31'b0, stall}, 0);
    @(negedge clk);
    dbus_ack = 0;
    @(negedge clk);
    chk("late_ack idle", {31'b0, dbus_req}, 0);
    chk("late_ack mem_data2", mem_data_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
